// File: rtl/ray_dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// ray_dispatch_scheduler
//
// Walks a WIDTH x HEIGHT frame in raster order and issues one pixel
// coordinate per cycle to a pool of NUM_CORES ray cores. Idle cores are
// picked round-robin, one in-flight pixel is tracked per core, and
// frame_done pulses only after every issued pixel has been retired.
//
// Optional build macro: DISPATCH_PERF_EN
//   When defined, adds a 32-bit frame_cycles output holding the number of
//   busy cycles of the most recently completed frame (saturating).
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous, active-high reset
//   frame_start     in   one-cycle request to render a frame (IDLE only)
//   core_ready      in   [NUM_CORES] core i can accept a pixel
//   core_done       in   [NUM_CORES] one-cycle pulse, core i retired its pixel
//   dispatch_valid  out  [NUM_CORES] one-hot pulse, pixel issued to core i
//   pixel_x         out  [10] x of the issued pixel (holds between issues)
//   pixel_y         out  [10] y of the issued pixel (holds between issues)
//   busy            out  high in any state other than IDLE
//   frame_done      out  one-cycle pulse at frame completion
//   frame_cycles    out  [32] busy cycles of last frame (DISPATCH_PERF_EN)
// ---------------------------------------------------------------------------
module ray_dispatch_scheduler #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [NUM_CORES-1:0] core_ready,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] dispatch_valid,
    output logic [9:0]           pixel_x,
    output logic [9:0]           pixel_y,
    output logic                 busy,
    output logic                 frame_done
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]          frame_cycles
`endif
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int IDX_W = PTR_W + 1;
    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [9:0]           x_q, x_d, y_q, y_d;
    logic [9:0]           px_q, px_d, py_q, py_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [NUM_CORES-1:0] inflight_q, inflight_d;
    logic [NUM_CORES-1:0] dv_q, dv_d;

    logic [NUM_CORES-1:0] eligible;
    logic                 grant;
    logic [PTR_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     idx;

    // Round-robin search: first eligible core at or after rr_q, wrapping.
    // A core retiring this cycle still has its in-flight bit set here, so
    // it cannot be re-granted until the following cycle.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that
        // no path leaves it unassigned, which would infer a latch.
        eligible  = core_ready & ~inflight_q;
        grant     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = {1'b0, rr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_CORES)) begin
                idx = idx - IDX_W'(NUM_CORES);
            end
            if (!grant && eligible[idx[PTR_W-1:0]]) begin
                grant     = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        px_d       = px_q;
        py_d       = py_q;
        rr_d       = rr_q;
        dv_d       = '0;
        // Retirements are honoured in every state; pulses for cores with
        // nothing in flight simply clear an already-clear bit.
        inflight_d = inflight_q & ~core_done;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (grant) begin
                    dv_d                  = NUM_CORES'(1) << grant_idx;
                    px_d                  = x_q;
                    py_d                  = y_q;
                    inflight_d[grant_idx] = 1'b1;
                    rr_d = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0
                                                                : grant_idx + PTR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            // Last pixel granted: counters wrap and lie
                            // unused until the next frame_start.
                            y_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            rr_q       <= '0;
            inflight_q <= '0;
            dv_q       <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            px_q       <= px_d;
            py_q       <= py_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            dv_q       <= dv_d;
        end
    end

    assign dispatch_valid = dv_q;
    assign pixel_x        = px_q;
    assign pixel_y        = py_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = (state_q == S_DONE);

`ifdef DISPATCH_PERF_EN
    logic [31:0] cyc_q, cyc_d, fc_q, fc_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // cyc_q counts busy cycles already elapsed in this frame. The snapshot
    // is taken on entry to DONE and includes the DONE cycle itself, so it
    // appears together with the frame_done pulse.
    always_comb begin
        cyc_d = cyc_q;
        fc_d  = fc_q;
        if (state_q == S_IDLE) begin
            if (frame_start) begin
                cyc_d = '0;
            end
        end else begin
            cyc_d = sat_inc(cyc_q);
        end
        if (state_q == S_DRAIN && state_d == S_DONE) begin
            fc_d = sat_inc(cyc_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            fc_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            fc_q  <= fc_d;
        end
    end

    assign frame_cycles = fc_q;
`endif

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for ray_dispatch_scheduler on a 4x2 frame with four cores.
// A behavioural model tracks the frame as a pixel index, a per-core busy
// mask and a rotating start pointer, and predicts every output each cycle.
// Inputs are driven and outputs compared on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ray_dispatch_scheduler;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = 4;

    localparam int P_IDLE  = 0;
    localparam int P_DISP  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic [N-1:0] core_ready;
    logic [N-1:0] core_done;
    logic [N-1:0] dispatch_valid;
    logic [9:0]   pixel_x;
    logic [9:0]   pixel_y;
    logic         busy;
    logic         frame_done;
`ifdef DISPATCH_PERF_EN
    logic [31:0]  frame_cycles;
`endif

    ray_dispatch_scheduler #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .NUM_CORES (N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .core_ready     (core_ready),
        .core_done      (core_done),
        .dispatch_valid (dispatch_valid),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .busy           (busy),
        .frame_done     (frame_done)
`ifdef DISPATCH_PERF_EN
        ,
        .frame_cycles   (frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Model state
    int           m_phase;
    logic [N-1:0] m_inf;
    int           m_rr;
    int           m_pix;
    logic [N-1:0] m_dv;
    int           m_x, m_y;
    int           m_busy_cnt;
    int           m_fc;

    // Core behaviour
    int           tmr[N];
    logic [N-1:0] extra_done;
    logic [N-1:0] hold_mask;
    bit           rand_lat, rand_ready, rand_fs;

    // Observations
    int           n_checks, n_fail;
    int           n_disp, n_fd, n_busy;
    logic [N-1:0] obs_dv[$];
    logic [19:0]  obs_xy[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_inf      = '0;
        m_rr       = 0;
        m_pix      = 0;
        m_dv       = '0;
        m_x        = 0;
        m_y        = 0;
        m_busy_cnt = 0;
        m_fc       = 0;
    endtask

    // One clock cycle: finish the inputs, predict, clock, compare.
    task automatic step();
        logic [N-1:0] done_v;
        logic [N-1:0] inf_old;
        int           g, c, lat;
        if (rand_ready) core_ready = N'($urandom);
        if (rand_fs) frame_start = ($urandom_range(0, 3) == 0);
        done_v = extra_done;
        for (int i = 0; i < N; i++) begin
            if (tmr[i] == 1) done_v[i] = 1'b1;
            if (tmr[i] > 0) tmr[i]--;
        end
        core_done = done_v;

        if (rst) begin
            model_reset();
        end else begin
            inf_old = m_inf;
            g = -1;
            if (m_phase == P_DISP) begin
                for (int j = 0; j < N; j++) begin
                    c = (m_rr + j) % N;
                    if (g < 0 && core_ready[c] && !inf_old[c]) g = c;
                end
            end
            m_inf = inf_old & ~done_v;
            m_dv  = '0;
            case (m_phase)
                P_IDLE: if (frame_start) begin
                    m_pix      = 0;
                    m_busy_cnt = 0;
                    m_phase    = P_DISP;
                end
                P_DISP: if (g >= 0) begin
                    m_dv[g]  = 1'b1;
                    m_x      = m_pix % W;
                    m_y      = m_pix / W;
                    m_inf[g] = 1'b1;
                    m_rr     = (g + 1) % N;
                    m_pix++;
                    lat      = rand_lat ? int'($urandom_range(1, 5)) : 3;
                    tmr[g]   = hold_mask[g] ? 0 : lat + 1;
                    if (m_pix == W * H) m_phase = P_DRAIN;
                end
                P_DRAIN: if (inf_old == '0) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
            if (m_phase != P_IDLE) m_busy_cnt++;
            if (m_phase == P_DONE) m_fc = m_busy_cnt;
        end

        @(posedge clk);
        @(negedge clk);

        check("dispatch_valid", 32'(dispatch_valid), 32'(m_dv));
        check("pixel_x", 32'(pixel_x), 32'(m_x));
        check("pixel_y", 32'(pixel_y), 32'(m_y));
        check("busy", 32'(busy), 32'(m_phase != P_IDLE));
        check("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
`ifdef DISPATCH_PERF_EN
        check("frame_cycles", frame_cycles, 32'(m_fc));
`endif
        if (dispatch_valid != '0) begin
            n_disp++;
            obs_dv.push_back(dispatch_valid);
            obs_xy.push_back({pixel_x, pixel_y});
        end
        if (frame_done) n_fd++;
        if (busy) n_busy++;
    endtask

    task automatic clear_obs();
        n_disp = 0;
        n_fd   = 0;
        n_busy = 0;
        obs_dv.delete();
        obs_xy.delete();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int k;
        k = 0;
        while (m_phase != P_IDLE && k < max_cycles) begin
            step();
            k++;
        end
        if (k >= max_cycles) check("frame_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [N-1:0] dv_at(input int i);
        return (i < obs_dv.size()) ? obs_dv[i] : '0;
    endfunction

    function automatic logic [19:0] xy_at(input int i);
        return (i < obs_xy.size()) ? obs_xy[i] : 20'hFFFFF;
    endfunction

    initial begin
        int k;
        rst         = 1'b1;
        frame_start = 1'b0;
        core_ready  = '0;
        core_done   = '0;
        extra_done  = '0;
        hold_mask   = '0;
        rand_lat    = 1'b0;
        rand_ready  = 1'b0;
        rand_fs     = 1'b0;
        n_checks    = 0;
        n_fail      = 0;
        for (int i = 0; i < N; i++) tmr[i] = 0;
        model_reset();
        clear_obs();
        @(negedge clk);

        // Reset state
        step();
        step();
        rst = 1'b0;
        step();

        // Stray retirement in IDLE changes nothing
        extra_done = 4'b0001;
        step();
        extra_done = '0;
        step();
        check("idle_stray_busy", 32'(busy), 32'd0);

        // Small frame, all cores ready, 3-cycle retirement; a second
        // frame_start during DISPATCH must be ignored.
        core_ready = 4'hF;
        clear_obs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run_until_idle(200);
        for (int i = 0; i < 5; i++) step();
        check("s1_dispatch_count", 32'(n_disp), 32'd8);
        check("s1_frame_done_count", 32'(n_fd), 32'd1);
        check("s1_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < W * H; i++) begin
            check("s1_core_order", 32'(dv_at(i)), 32'(1 << (i % N)));
            check("s1_coord", 32'(xy_at(i)), 32'({10'(i % W), 10'(i / W)}));
        end
`ifdef DISPATCH_PERF_EN
        check("s1_frame_cycles_measured", frame_cycles, 32'(n_busy));
`endif

        // Reset mid-frame after three dispatches
        clear_obs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        k = 0;
        while (n_disp < 3 && k < 50) begin
            step();
            k++;
        end
        check("rst_mid_reached_3", 32'(n_disp), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_dv", 32'(dispatch_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_xy", 32'({pixel_x, pixel_y}), 32'd0);

        // Round-robin skip with only cores 1 and 3 ready
        core_ready = 4'b1010;
        clear_obs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run_until_idle(400);
        check("rr_first_core", 32'(dv_at(0)), 32'h2);
        check("rr_first_xy", 32'(xy_at(0)), 32'd0);
        check("rr_second_core", 32'(dv_at(1)), 32'h8);
        check("rr_third_core", 32'(dv_at(2)), 32'h2);
        check("rr_dispatch_count", 32'(n_disp), 32'd8);

        // Drain: core 2 never retires on its own
        core_ready = 4'hF;
        hold_mask  = 4'b0100;
        clear_obs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        k = 0;
        while (m_phase != P_DRAIN && k < 200) begin
            step();
            k++;
        end
        for (int i = 0; i < 10; i++) step();
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_no_done", 32'(frame_done), 32'd0);
        extra_done = 4'b0100;
        step();
        extra_done = '0;
        check("drain_n1_done", 32'(frame_done), 32'd0);
        step();
        check("drain_n2_done", 32'(frame_done), 32'd1);
        step();
        check("drain_idle_after", 32'(busy), 32'd0);
        hold_mask = '0;

        // Randomised frames: random readiness, latency and stray requests
        rand_lat   = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            clear_obs();
            rand_fs     = 1'b0;
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            rand_fs     = 1'b1;
            run_until_idle(2000);
            rand_fs     = 1'b0;
            frame_start = 1'b0;
            check("rand_dispatch_count", 32'(n_disp), 32'(W * H));
            check("rand_frame_done_count", 32'(n_fd), 32'd1);
        end
        rand_ready = 1'b0;
        rand_lat   = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ray_dispatch_scheduler.md
Name: ray_dispatch_scheduler

Overview:
- Frame-level scheduler that walks the screen in raster order and hands one pixel coordinate per cycle to a pool of NUM_CORES ray cores.
- Selects among idle cores with round-robin arbitration and tracks one in-flight pixel per core.
- Signals frame completion only after every dispatched pixel has been retired.
- Sits between the frame controller (frame_start / frame_done) and the ray core array.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- NUM_CORES, 4, number of ray cores served; range 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle request to render a frame
- core_ready  in  NUM_CORES  core i can accept a pixel
- core_done  in  NUM_CORES  one-cycle pulse: core i retired its pixel
- dispatch_valid  out  NUM_CORES  one-hot (or zero) pulse: pixel issued to core i
- pixel_x  out  10  x coordinate of the issued pixel
- pixel_y  out  10  y coordinate of the issued pixel
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: state=IDLE, dispatch_valid=0, pixel_x=0, pixel_y=0, busy=0, frame_done=0, all in-flight bits=0, rr_ptr=0, internal x/y counters=0.
- States and transitions:
  - IDLE: on frame_start, clear the x/y counters and go to DISPATCH.
  - DISPATCH: issue pixels. After the grant of (WIDTH-1, HEIGHT-1), go to DRAIN.
  - DRAIN: wait until all in-flight bits are 0, then go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then return to IDLE.
- frame_start in any state other than IDLE is ignored; it is not queued.
- Eligibility: core i is eligible when core_ready[i]=1 and inflight[i]=0, evaluated on the current cycle's inputs and registered state.
- Arbitration:
  - At most one grant per cycle.
  - Search starts at rr_ptr and wraps modulo NUM_CORES; the first eligible core k wins.
  - After a grant, rr_ptr = (k+1) mod NUM_CORES. rr_ptr holds when there is no grant.
- Grant effects:
  - Next cycle: dispatch_valid = one-hot(k); pixel_x/pixel_y = current counter values.
  - inflight[k] set.
  - Counters advance: x+1; at x=WIDTH-1, x=0 and y+1.
- Latency: 1 cycle from the eligibility decision to the registered dispatch outputs.
- pixel_x/pixel_y hold their last value when dispatch_valid=0.
- core_done[i]:
  - Clears inflight[i].
  - Ignored when inflight[i]=0.
  - Accepted in every state, including IDLE; no error is raised.
  - A core that retires in cycle n may be granted again in cycle n+1, but not in cycle n.
- No eligible core in DISPATCH: stall with counters unchanged; there is no timeout.
- Final pixel: no further grants are made; the counters wrap to 0 but are not used until the next frame_start.
- Width rule: coordinates are 10 bits wide, so WIDTH and HEIGHT must be ≤ 1024.
- Reset mid-frame: all state returns to reset values in the next cycle. In-flight pixels are abandoned, and later core_done pulses for them are ignored.

Optional Feature:
- Macro: DISPATCH_PERF_EN.
- Defined:
  - Adds output frame_cycles, 32 bits.
  - An internal counter clears on the frame_start accept, increments on every cycle while busy=1, and saturates at 0xFFFFFFFF.
  - frame_cycles loads the final count in the same cycle as frame_done and holds it until the next frame_done.
  - Reset value of frame_cycles is 0.
- Not defined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Small frame, all cores ready:
  - Setup: WIDTH=4, HEIGHT=2, NUM_CORES=4, core_ready=4'hF; each core returns core_done 3 cycles after its dispatch.
  - Required: dispatches go to cores 0,1,2,3,0,… in order, with coordinates (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1).
  - Required: exactly 8 dispatches, one frame_done pulse, then busy=0.
- Round-robin skip: core_ready=4'b1010 with rr_ptr=0 → first grant to core 1, next to core 3, then core 1 again once it retires.
- Drain:
  - Setup: hold core 2 busy with no core_done after the last pixel.
  - Required: state stays DRAIN and frame_done=0.
  - Required: core_done[2] in cycle n → frame_done=1 in cycle n+2 (DRAIN→DONE at n+1, pulse registered in DONE).
- Ignored requests:
  - frame_start pulsed during DISPATCH → no counter reset and no second frame_done.
  - Stray core_done[0] in IDLE → no state change.
- Reset mid-frame:
  - Assert rst after 3 dispatches → next cycle all outputs are 0 and the state is IDLE.
  - A new frame_start then dispatches (0,0) first.
- DISPATCH_PERF_EN: using the first scenario, frame_cycles equals the measured number of busy cycles, and holds that value after frame_done.
